// File: rtl/ifetch_queue.sv
// ============================================================================
// ifetch_queue -- instruction fetch front end for the 8-bit pipelined MCU
//
// Generates sequential program-memory read addresses, absorbs the memory's
// one-cycle read latency in a small FIFO, and hands decode one instruction per
// cycle together with its PC+1. Decode stalls hold the head stable; a redirect
// from execute flushes the FIFO, squashes the in-flight read and refetches
// from the new address in the same cycle.
//
// Optional build macro:
//   IFQ_BYPASS_EN  - when the FIFO is empty, current-epoch read data is shown
//                    to decode in the cycle it returns (1-cycle latency
//                    instead of 2). Undefined: data always goes via the FIFO.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   imem_en      out  program memory read request this cycle
//   imem_addr    out  program memory read address
//   imem_rdata   in   read data, valid one cycle after the request
//   stall        in   decode cannot accept an instruction this cycle
//   redirect     in   taken branch/jump: flush and refetch
//   redirect_pc  in   new fetch address when redirect=1
//   inst_valid   out  inst/inst_pc1 hold a real instruction
//   inst         out  head instruction, zero (NOP) when inst_valid=0
//   inst_pc1     out  address of head instruction + 1
//   q_count      out  current FIFO occupancy
// ============================================================================
module ifetch_queue #(
    parameter int                 ADDR_W   = 8,
    parameter int                 INST_W   = 17,
    parameter int                 DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      imem_en,
    output logic [ADDR_W-1:0]         imem_addr,
    input  logic [INST_W-1:0]         imem_rdata,
    input  logic                      stall,
    input  logic                      redirect,
    input  logic [ADDR_W-1:0]         redirect_pc,
    output logic                      inst_valid,
    output logic [INST_W-1:0]         inst,
    output logic [ADDR_W-1:0]         inst_pc1,
    output logic [$clog2(DEPTH):0]    q_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    // Occupancy plus in-flight can reach DEPTH, so compare in one extra bit.
    localparam logic [CW:0] DEPTH_V = DEPTH[CW:0];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] fpc_reg;
    logic [AW-1:0]     head_reg;
    logic [AW-1:0]     tail_reg;
    logic [CW-1:0]     count_reg;
    logic              epoch_reg;

    // One outstanding read: {valid, addr, epoch}
    logic              infl_valid_reg;
    logic [ADDR_W-1:0] infl_addr_reg;
    logic              infl_epoch_reg;

    // The head must be visible in the same cycle it becomes valid, so the
    // storage is a small register file read combinationally at head_reg.
    logic [INST_W-1:0] fifo_inst [DEPTH];
    logic [ADDR_W-1:0] fifo_pc1  [DEPTH];

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic              ret_valid;
    logic [ADDR_W-1:0] ret_pc1;
    logic              fifo_empty;
    logic              bypass;
    logic              pop;
    logic              pop_fifo;
    logic              push;
    logic [CW-1:0]     eff_count;
    logic              eff_infl;
    logic [CW:0]       occ_sum;
    logic [CW-1:0]     count_next;

    // Returning data is only kept if it belongs to the current epoch and is
    // not being discarded by a redirect or reset in this same cycle.
    assign ret_valid  = infl_valid_reg && (infl_epoch_reg == epoch_reg)
                        && !reset && !redirect;
    assign ret_pc1    = infl_addr_reg + 1'b1;
    assign fifo_empty = (count_reg == '0);

`ifdef IFQ_BYPASS_EN
    assign bypass = fifo_empty && ret_valid;
`else
    assign bypass = 1'b0;
`endif

    assign inst_valid = !reset && (!fifo_empty || bypass);
    assign pop        = inst_valid && !stall && !redirect;
    // A bypassed word that decode accepts never enters the FIFO; a stalled
    // bypassed word is written so it is still there next cycle.
    assign pop_fifo   = pop && !bypass;
    assign push       = ret_valid && !(bypass && pop);

    assign eff_count  = redirect ? '0 : (count_reg - {{(CW-1){1'b0}}, pop_fifo});
    assign eff_infl   = redirect ? 1'b0 : push;
    assign occ_sum    = {1'b0, eff_count} + {{CW{1'b0}}, eff_infl};

    assign imem_addr  = redirect ? redirect_pc : fpc_reg;
    assign imem_en    = !reset && (occ_sum < DEPTH_V);

    assign count_next = count_reg + {{(CW-1){1'b0}}, push}
                                  - {{(CW-1){1'b0}}, pop_fifo};

    always_comb begin
        inst     = '0;
        inst_pc1 = '0;
        if (inst_valid) begin
            if (bypass) begin
                inst     = imem_rdata;
                inst_pc1 = ret_pc1;
            end else begin
                inst     = fifo_inst[head_reg];
                inst_pc1 = fifo_pc1[head_reg];
            end
        end
    end

    assign q_count = reset ? '0 : count_reg;

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            fpc_reg        <= RESET_PC;
            head_reg       <= '0;
            tail_reg       <= '0;
            count_reg      <= '0;
            epoch_reg      <= 1'b0;
            infl_valid_reg <= 1'b0;
            infl_addr_reg  <= '0;
            infl_epoch_reg <= 1'b0;
        end else begin
            if (imem_en) begin
                fpc_reg <= imem_addr + 1'b1;
            end

            // The request issued on a redirect cycle belongs to the new epoch.
            infl_valid_reg <= imem_en;
            infl_addr_reg  <= imem_addr;
            infl_epoch_reg <= redirect ? ~epoch_reg : epoch_reg;

            if (redirect) begin
                epoch_reg <= ~epoch_reg;
                head_reg  <= '0;
                tail_reg  <= '0;
                count_reg <= '0;
            end else begin
                if (push) begin
                    tail_reg <= tail_reg + 1'b1;
                end
                if (pop_fifo) begin
                    head_reg <= head_reg + 1'b1;
                end
                count_reg <= count_next;
            end
        end
    end

    // Storage has no reset; occupancy is tracked by count/head/tail.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst[tail_reg] <= imem_rdata;
            fifo_pc1[tail_reg]  <= ret_pc1;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// ============================================================================
// tb_ifetch_queue -- self-checking bench for ifetch_queue (default build).
// Program memory model: word[a] = 0x100 + a, registered read.
// A scoreboard holds the expected instruction stream; a negedge monitor pops
// and compares every instruction decode accepts.
// ============================================================================
module tb_ifetch_queue;

    localparam int ADDR_W = 8;
    localparam int INST_W = 17;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              reset;
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0] imem_rdata;
    logic              stall;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              inst_valid;
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc1;
    logic [$clog2(DEPTH):0] q_count;

    int total = 0;
    int bad   = 0;

    logic [INST_W+ADDR_W-1:0] sb_q[$];
    logic [INST_W+ADDR_W-1:0] sb_e;

    ifetch_queue #(
        .ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH), .RESET_PC(8'h00)
    ) dut (
        .clk(clk), .reset(reset),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst(inst), .inst_pc1(inst_pc1),
        .q_count(q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [INST_W-1:0] word(input logic [ADDR_W-1:0] a);
        return 17'h100 + {9'b0, a};
    endfunction

    // Synchronous program memory, one-cycle latency
    initial imem_rdata = '0;
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= word(imem_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Expected stream from a fetch start address: word[a], pc1 = a+1 (wrapping)
    task automatic sb_restart(input logic [ADDR_W-1:0] start);
        logic [ADDR_W-1:0] a;
        sb_q.delete();
        a = start;
        for (int i = 0; i < 64; i++) begin
            sb_q.push_back({word(a), ADDR_W'(a + 8'd1)});
            a = a + 8'd1;
        end
    endtask

    // Monitor: every accepted instruction must be the next expected one
    always @(negedge clk) begin
        if (!reset && inst_valid && !stall && !redirect) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_inst: got 0x%0h expected none", inst);
            end else begin
                sb_e = sb_q.pop_front();
                chk("pop_inst", 32'(inst), 32'(sb_e[INST_W+ADDR_W-1:ADDR_W]));
                chk("pop_pc1", 32'(inst_pc1), 32'(sb_e[ADDR_W-1:0]));
            end
        end else if (!reset && !inst_valid) begin
            chk("bubble_nop", 32'(inst), 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;

        // ---- reset state ----
        step(); step(); step();
        mid();
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", 32'(inst), 32'd0);
        chk("rst_pc1", 32'(inst_pc1), 32'd0);
        chk("rst_qcount", 32'(q_count), 32'd0);
        chk("rst_en", 32'(imem_en), 32'd0);

        // ---- release: sequential fetch, 2-cycle latency ----
        step(); reset = 1'b0; sb_restart(8'h00);
        mid();
        chk("c0_en", 32'(imem_en), 32'd1);
        chk("c0_addr", 32'(imem_addr), 32'h00);
        chk("c0_valid", 32'(inst_valid), 32'd0);
        step(); mid();
        chk("c1_addr", 32'(imem_addr), 32'h01);
        chk("c1_valid", 32'(inst_valid), 32'd0);
        step(); stall = 1'b1; mid();
        chk("c2_valid", 32'(inst_valid), 32'd1);
        chk("c2_inst", 32'(inst), 32'h100);
        chk("c2_pc1", 32'(inst_pc1), 32'h01);

        // ---- hold stall for 10 cycles ----
        repeat (9) begin
            step(); mid();
            chk("stall_hold_inst", 32'(inst), 32'h100);
        end
        chk("stall_qcount_full", 32'(q_count), 32'd4);
        chk("stall_en_off", 32'(imem_en), 32'd0);

        // ---- release stall: consecutive stream ----
        step(); stall = 1'b0; mid();
        repeat (8) begin
            step(); mid();
            chk("stream_no_gap", 32'(inst_valid), 32'd1);
        end

        // ---- mid-stream reset with a read in flight ----
        chk("pre_rst_en", 32'(imem_en), 32'd1);
        step(); reset = 1'b1; mid();
        chk("mrst_valid", 32'(inst_valid), 32'd0);
        chk("mrst_inst", 32'(inst), 32'd0);
        chk("mrst_pc1", 32'(inst_pc1), 32'd0);
        chk("mrst_qcount", 32'(q_count), 32'd0);
        chk("mrst_en", 32'(imem_en), 32'd0);
        step(); reset = 1'b0; stall = 1'b1; sb_restart(8'h00);
        mid();
        chk("mrst_restart_addr", 32'(imem_addr), 32'h00);
        chk("mrst_restart_valid", 32'(inst_valid), 32'd0);
        step(); mid();
        step(); mid();
        chk("mrst_first_inst", 32'(inst), 32'h100);
        step(); mid();

        // ---- redirect: 3 entries + read in flight, stalled pop-eligible head ----
        step(); redirect = 1'b1; redirect_pc = 8'h40; mid();
        chk("redir_qcount_before", 32'(q_count), 32'd3);
        chk("redir_head_valid", 32'(inst_valid), 32'd1);
        chk("redir_addr", 32'(imem_addr), 32'h40);
        chk("redir_en", 32'(imem_en), 32'd1);
        sb_restart(8'h40);
        step(); redirect = 1'b0; stall = 1'b0; mid();
        chk("redir_qcount_after", 32'(q_count), 32'd0);
        chk("redir_bubble", 32'(inst_valid), 32'd0);
        step(); mid();
        chk("redir_valid", 32'(inst_valid), 32'd1);
        chk("redir_inst", 32'(inst), 32'h140);
        chk("redir_pc1", 32'(inst_pc1), 32'h41);
        repeat (3) begin step(); mid(); end

        // ---- address wrap from 0xFE ----
        step(); redirect = 1'b1; redirect_pc = 8'hFE; mid();
        chk("wrap_addr_fe", 32'(imem_addr), 32'hFE);
        sb_restart(8'hFE);
        step(); redirect = 1'b0; mid();
        chk("wrap_addr_ff", 32'(imem_addr), 32'hFF);
        step(); mid();
        chk("wrap_addr_00", 32'(imem_addr), 32'h00);
        chk("wrap_first_inst", 32'(inst), 32'h1FE);
        step(); mid();
        chk("wrap_ff_pc1", 32'(inst_pc1), 32'h00);
        repeat (5) begin step(); mid(); end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
